pwm_capture_16bits: RTL and testbench
=====================================

Name: pwm_capture_16bits

Overview:
- Receive-side counterpart of the 16-bit PWM generator: samples an external or looped-back PWM waveform and measures its period and high time in prescaled clock ticks.
- Used for closed-loop self-test of generated PWM and for reading external PWM feedback.
- Sits beside the PWM generator and shares its clock, reset, on/off enable type and 5-bit divider convention.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the pwm_in synchronizer chain (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  system reset, synchronous, active-low.
- pwm_in  input  1  asynchronous PWM waveform to measure.
- cap_divider  input  5  prescaler; count tick every (cap_divider+1) clk cycles.
- pwm_onoff  input  _pwm_onoff  capture enable (PKG_pwm type).
- period_meas  output  16  last measured period, rise to rise, in ticks.
- high_meas  output  16  last measured high time, rise to fall, in ticks.
- meas_valid  output  1  one-clk pulse when period_meas/high_meas update.
- timeout  output  1  sticky; no complete cycle seen within 16'hFFFF ticks.
- level  output  1  synchronized pwm_in level.

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0, FSM to IDLE, counters and prescaler 0.
- Sync: pwm_in passes through SYNC_STAGES flip-flops, plus one history flip-flop.
  - rise = sync & ~hist; fall = ~sync & hist; at most one event per clk.
  - level = sync.
- Prescaler: tick when prescaler count == cap_divider, then wrap to 0. Prescaler is forced to 0 on every rise event so ticks are phase-aligned to the rising edge.
- Counters: cnt_per and cnt_high are 16-bit, cleared on rise and incremented on tick.
  - With cap_divider=0: a waveform of P clk period and H clk high gives period_meas=P, high_meas=H exactly.
  - With cap_divider=d and P, H multiples of (d+1): results are P/(d+1) and H/(d+1).
- FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
  - IDLE: pwm_onoff==PWM_ON -> WAIT_RISE.
  - WAIT_RISE: rise -> MEAS_HIGH, clear counters; no output update.
  - MEAS_HIGH: fall -> latch cnt_high into shadow register, -> MEAS_LOW.
  - MEAS_LOW: rise -> period_meas<=cnt_per, high_meas<=shadow, meas_valid=1 for one clk, timeout<=0, clear counters, -> MEAS_HIGH.
- Latency: meas_valid is high in the clk cycle after the (SYNC_STAGES+1)th clk edge that samples pwm_in high. This is 3 edges for the default parameter.
- Timeout: in MEAS_HIGH or MEAS_LOW, when cnt_per reaches 16'hFFFF on a tick:
  - timeout<=1, -> WAIT_RISE, counters cleared, measurement outputs held.
  - Covers 0% and 100% duty and a stopped source.
  - Counters saturate and never wrap.
- pwm_onoff==PWM_OFF in any state: -> IDLE next clk, counters and prescaler cleared, meas_valid=0. period_meas, high_meas and timeout are held. level keeps tracking pwm_in.
- cap_divider change mid-measurement: takes effect at the next tick compare. The first result after the change is not guaranteed.
- Reset mid-measurement: same as the reset row above; no meas_valid is emitted.
- Pulses shorter than one clk may be missed; this is not an error.

Decomposition:
- Add to PKG_pwm:
  - typedef enum _cap_state {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW}.
  - localparam CAP_CNT_MAX = 16'hFFFF.
- Reuse the existing _pwm_onoff type.
- One sub-module: pwm_in_sync, containing the SYNC_STAGES synchronizer, history flip-flop and rise/fall/level outputs.
- Prescaler, counters and FSM stay in the top module. div_clock is not reused because a tick enable is required, not a derived clock.

Test Plan:
- Reset: hold reset=0 for 5 clk with pwm_in toggling -> all outputs 0, no meas_valid.
- Basic: cap_divider=0, PWM_ON, pwm_in period 100 clk, high 30 clk -> from the 2nd rise onward, meas_valid once per period with period_meas=100, high_meas=30, timeout=0.
- Prescale: cap_divider=3, period 400 clk, high 120 clk -> period_meas=100, high_meas=30.
- Duty extremes: pwm_in constant 1 after one rise, cap_divider=0 -> timeout=1 after 65535 ticks, outputs held. Then drive period 50, high 25 -> timeout=0 and period_meas=50 at the next valid.
- Disable mid-cycle: PWM_OFF during MEAS_HIGH -> no meas_valid, prior values held. Re-enable -> first valid one full period after the first new rise.
- Generator loopback: connect the PWM generator's pwm output (period=999, up-count, pwm clock divider 0) to pwm_in -> period_meas equals the generator carrier period in clk cycles, and high_meas matches the compare setting.

Source files
------------

// File: rtl/pwm_capture_16bits_pkg.sv
// Shared PWM types: generator enable type, capture FSM states and counter limit.
package pwm_capture_16bits_pkg;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } _cap_state;

  localparam logic [15:0] CAP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pwm_capture_16bits_in_sync.sv
// Synchronizes the asynchronous pwm_in and derives single-cycle rise/fall events.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/pwm_capture_16bits.sv
// Measures period and high time of a PWM waveform in prescaled ticks, rise to rise.
// meas_valid is a one-cycle strobe with no ready: the consumer must take the values that cycle.
module pwm_capture_16bits
  import pwm_capture_16bits_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  input  logic [4:0]  cap_divider,
  input  _pwm_onoff   pwm_onoff,
  output logic [15:0] period_meas,
  output logic [15:0] high_meas,
  output logic        meas_valid,
  output logic        timeout,
  output logic        level
);

  logic rise, fall;

  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall),
    .level  (level)
  );

  _cap_state   state_q, state_d;
  logic [4:0]  presc_q;
  logic [15:0] cnt_per_q, cnt_high_q, shadow_q, period_q, high_q;
  logic        valid_q, timeout_q;

  logic        tick, cnt_full;
  logic [15:0] cnt_per_inc, cnt_high_inc;
  logic        clr_cnt, latch_high, latch_meas, set_timeout;

  // >= lets a lowered divider recover at the next compare instead of wrapping through 31.
  assign tick         = (presc_q >= cap_divider);
  assign cnt_full     = tick && (cnt_per_q == CAP_CNT_MAX);
  // The tick coinciding with the closing edge belongs to the measured interval.
  assign cnt_per_inc  = (tick && cnt_per_q  != CAP_CNT_MAX) ? cnt_per_q  + 16'd1 : cnt_per_q;
  assign cnt_high_inc = (tick && cnt_high_q != CAP_CNT_MAX) ? cnt_high_q + 16'd1 : cnt_high_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt     = 1'b0;
    latch_high  = 1'b0;
    latch_meas  = 1'b0;
    set_timeout = 1'b0;
    if (pwm_onoff == PWM_OFF) begin
      state_d = IDLE;
      clr_cnt = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          clr_cnt = 1'b1;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_d = MEAS_HIGH;
            clr_cnt = 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (cnt_full) begin
            state_d     = WAIT_RISE;
            set_timeout = 1'b1;
            clr_cnt     = 1'b1;
          end else if (fall) begin
            state_d    = MEAS_LOW;
            latch_high = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            state_d    = MEAS_HIGH;
            latch_meas = 1'b1;
            clr_cnt    = 1'b1;
          end else if (cnt_full) begin
            state_d     = WAIT_RISE;
            set_timeout = 1'b1;
            clr_cnt     = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          clr_cnt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      cnt_per_q  <= '0;
      cnt_high_q <= '0;
      shadow_q   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= latch_meas;
      if (clr_cnt || rise || tick) presc_q <= '0;
      else                         presc_q <= presc_q + 5'd1;
      if (clr_cnt) begin
        cnt_per_q  <= '0;
        cnt_high_q <= '0;
      end else begin
        cnt_per_q  <= cnt_per_inc;
        cnt_high_q <= cnt_high_inc;
      end
      if (latch_high) shadow_q <= cnt_high_inc;
      if (latch_meas) begin
        period_q  <= cnt_per_inc;
        high_q    <= shadow_q;
        timeout_q <= 1'b0;
      end
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  assign period_meas = period_q;
  assign high_meas   = high_q;
  assign meas_valid  = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Self-checking bench for pwm_capture_16bits: waveform driver, loopback generator, scoreboard queues.
module tb_pwm_capture_16bits;
  import pwm_capture_16bits_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int GEN_PERIOD  = 999;
  localparam int GEN_CMP     = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_drv;
  logic        pwm_in;
  logic [4:0]  cap_divider;
  _pwm_onoff   pwm_onoff;
  logic [15:0] period_meas, high_meas;
  logic        meas_valid, timeout, level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [32:0] obs_q[$];
  int          obs_cyc_q[$];

  pwm_capture_16bits #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .cap_divider (cap_divider),
    .pwm_onoff   (pwm_onoff),
    .period_meas (period_meas),
    .high_meas   (high_meas),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .level       (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Up-counting generator stand-in: counts 0..GEN_PERIOD, high while count < GEN_CMP.
  logic       loop_sel;
  logic [9:0] gen_cnt;
  logic       gen_pwm;
  always @(posedge clk) begin
    if (!reset) gen_cnt <= '0;
    else        gen_cnt <= (gen_cnt == 10'(GEN_PERIOD)) ? 10'd0 : gen_cnt + 10'd1;
  end
  assign gen_pwm = (gen_cnt < 10'(GEN_CMP));
  assign pwm_in  = loop_sel ? gen_pwm : pwm_drv;

  always @(negedge clk) begin
    if (meas_valid) begin
      obs_q.push_back({timeout, period_meas, high_meas});
      obs_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic drive_period(input int p, input int h, input int div, input bit push);
    if (push) exp_q.push_back({16'(p / (div + 1)), 16'(h / (div + 1))});
    pwm_drv = 1'b1;
    repeat (h) @(posedge clk);
    #1 pwm_drv = 1'b0;
    repeat (p - h) @(posedge clk);
    #1;
  endtask

  task automatic start_capture(input int div);
    pwm_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 cap_divider = 5'(div);
    pwm_onoff = PWM_ON;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic stop_capture();
    pwm_onoff = PWM_OFF;
    pwm_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    pwm_onoff = PWM_OFF;
    cap_divider = 5'd0;
    pwm_drv = 1'b0;
    loop_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({period_meas, high_meas, meas_valid, timeout, level} !== 35'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got per=%0d high=%0d v=%0b to=%0b lvl=%0b, want all 0",
                 i, period_meas, high_meas, meas_valid, timeout, level);
      end
      @(posedge clk);
      #1 pwm_drv = ~pwm_drv;
    end
    reset = 1'b1;
    pwm_drv = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    @(negedge clk);
    checks++;
    if (level !== 1'b1) begin
      errors++;
      $display("FAIL level_track: got %0b want 1", level);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_valid: got %0d pulses want 0", obs_q.size());
    end
    @(posedge clk);
    #1 pwm_drv = 1'b0;
    clear_queues();
  endtask

  task automatic test_basic();
    int t_rise;
    logic [31:0] e;
    logic [32:0] o;
    clear_queues();
    start_capture(0);
    for (int i = 0; i < 4; i++) drive_period(100, 30, 0, 1'b1);
    pwm_drv = 1'b1;
    t_rise = cyc;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d want 4", obs_q.size());
    end
    checks++;
    if (obs_cyc_q.size() > 0 && obs_cyc_q[obs_cyc_q.size()-1] - t_rise != SYNC_STAGES + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d", obs_cyc_q[obs_cyc_q.size()-1] - t_rise, SYNC_STAGES + 1);
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== {1'b0, e}) begin
        errors++;
        $display("FAIL basic_meas[%0d]: got per=%0d high=%0d to=%0b, want per=%0d high=%0d to=0",
                 i, o[31:16], o[15:0], o[32], e[31:16], e[15:0]);
      end
    end
    stop_capture();
  endtask

  task automatic test_prescale();
    logic [31:0] e;
    logic [32:0] o;
    clear_queues();
    start_capture(3);
    for (int i = 0; i < 3; i++) drive_period(400, 120, 3, 1'b1);
    pwm_drv = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL prescale_count: got %0d want 3", obs_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== {1'b0, e}) begin
        errors++;
        $display("FAIL prescale_meas[%0d]: got per=%0d high=%0d to=%0b, want per=%0d high=%0d to=0",
                 i, o[31:16], o[15:0], o[32], e[31:16], e[15:0]);
      end
    end
    stop_capture();
  endtask

  task automatic test_random();
    int d, n, pn, hn, want;
    logic [31:0] e;
    logic [32:0] o;
    for (int it = 0; it < 6; it++) begin
      clear_queues();
      d = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      start_capture(d);
      for (int k = 0; k < n; k++) begin
        pn = $urandom_range(3, 30);
        hn = $urandom_range(1, pn - 1);
        drive_period(pn * (d + 1), hn * (d + 1), d, 1'b1);
      end
      pwm_drv = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      want = exp_q.size();
      checks++;
      if (obs_q.size() != want) begin
        errors++;
        $display("FAIL random_count[%0d]: got %0d want %0d", it, obs_q.size(), want);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o !== {1'b0, e}) begin
          errors++;
          $display("FAIL random_meas[%0d.%0d] div=%0d: got per=%0d high=%0d to=%0b, want per=%0d high=%0d to=0",
                   it, i, d, o[31:16], o[15:0], o[32], e[31:16], e[15:0]);
        end
      end
      stop_capture();
    end
  endtask

  task automatic test_duty_extremes();
    int t_rise, t_to;
    bit found;
    logic [31:0] e;
    logic [32:0] o;
    clear_queues();
    start_capture(0);
    drive_period(60, 20, 0, 1'b1);
    pwm_drv = 1'b1;
    t_rise = cyc;
    found = 1'b0;
    t_to = 0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        found = 1'b1;
        t_to = cyc;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL timeout_seen: got 0 want 1 within 70000 cycles");
    end
    checks++;
    if (found && t_to - t_rise != SYNC_STAGES + 1 + 65536) begin
      errors++;
      $display("FAIL timeout_time: got %0d want %0d", t_to - t_rise, SYNC_STAGES + 1 + 65536);
    end
    checks++;
    if (period_meas !== 16'd60 || high_meas !== 16'd20) begin
      errors++;
      $display("FAIL timeout_held: got per=%0d high=%0d want per=60 high=20", period_meas, high_meas);
    end
    @(posedge clk);
    #1 pwm_drv = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    drive_period(50, 25, 0, 1'b1);
    drive_period(50, 25, 0, 1'b1);
    pwm_drv = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %0b want 0", timeout);
    end
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL duty_count: got %0d want 3", obs_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== {1'b0, e}) begin
        errors++;
        $display("FAIL duty_meas[%0d]: got per=%0d high=%0d to=%0b, want per=%0d high=%0d to=0",
                 i, o[31:16], o[15:0], o[32], e[31:16], e[15:0]);
      end
    end
    stop_capture();
  endtask

  task automatic test_disable();
    int t_first;
    clear_queues();
    start_capture(0);
    drive_period(70, 30, 0, 1'b1);
    pwm_drv = 1'b1;
    repeat (10) @(posedge clk);
    #1 pwm_onoff = PWM_OFF;
    repeat (3) @(posedge clk);
    #1;
    drive_period(40, 20, 0, 1'b0);
    drive_period(40, 20, 0, 1'b0);
    pwm_drv = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (level !== 1'b1) begin
      errors++;
      $display("FAIL disable_level: got %0b want 1", level);
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL disable_count: got %0d want 1", obs_q.size());
    end
    checks++;
    if (period_meas !== 16'd70 || high_meas !== 16'd30 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL disable_held: got per=%0d high=%0d to=%0b want per=70 high=30 to=0",
               period_meas, high_meas, timeout);
    end
    @(posedge clk);
    #1;
    start_capture(0);
    t_first = cyc;
    drive_period(60, 20, 0, 1'b1);
    pwm_drv = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL reenable_count: got %0d want 2", obs_q.size());
    end
    if (obs_q.size() >= 2) begin
      checks++;
      if (obs_q[1] !== {1'b0, 16'd60, 16'd20}) begin
        errors++;
        $display("FAIL reenable_meas: got per=%0d high=%0d to=%0b want per=60 high=20 to=0",
                 obs_q[1][31:16], obs_q[1][15:0], obs_q[1][32]);
      end
      checks++;
      if (obs_cyc_q[1] - t_first != 60 + SYNC_STAGES + 1) begin
        errors++;
        $display("FAIL reenable_latency: got %0d want %0d", obs_cyc_q[1] - t_first, 60 + SYNC_STAGES + 1);
      end
    end
    stop_capture();
  endtask

  task automatic test_loopback();
    logic [32:0] o;
    logic [32:0] want;
    clear_queues();
    want = {1'b0, 16'(GEN_PERIOD + 1), 16'(GEN_CMP)};
    loop_sel = 1'b1;
    cap_divider = 5'd0;
    pwm_onoff = PWM_ON;
    repeat (3400) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() < 2) begin
      errors++;
      $display("FAIL loopback_count: got %0d want at least 2", obs_q.size());
    end
    for (int i = 0; obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      checks++;
      if (o !== want) begin
        errors++;
        $display("FAIL loopback_meas[%0d]: got per=%0d high=%0d to=%0b, want per=%0d high=%0d to=0",
                 i, o[31:16], o[15:0], o[32], want[31:16], want[15:0]);
      end
    end
    stop_capture();
    loop_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_random();
    test_duty_extremes();
    test_disable();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
